// File: rtl/jtframe_sdram_mux_pkg.sv
// Shared types and arbitration helper for the N-channel SDRAM bank multiplexer.
package jtframe_sdram_mux_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int MAX_CH = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of cand at or above ptr, wrapping modulo ch. ptr=0 gives fixed priority.
    function automatic pick_t rr_pick(input logic [MAX_CH-1:0] cand, input logic [2:0] ptr,
                                      input int ch);
        pick_t      p;
        logic [3:0] idx;
        p = '0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(ch)) idx = idx - 4'(ch);
            if (k < ch && !p.found && cand[idx[2:0]]) begin
                p.found = 1'b1;
                p.idx   = idx[2:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/jtframe_sdram_mux_cache.sv
// One-entry read cache for a single client channel: tag, data, valid and registered ok.
module jtframe_sdram_mux_cache
    import jtframe_sdram_mux_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 16
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          inval,
    output logic          hit,
    output logic          ok,
    output logic [DW-1:0] dout
);

    logic [AW-1:0] tag;
    logic          valid;

    assign hit = cs & valid & ~wr & (addr == tag);

    // Invalidation wins over a same-edge load so data fetched during a download stays invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag   <= '0;
            dout  <= '0;
            valid <= 1'b0;
            ok    <= 1'b0;
        end else begin
            ok <= hit;
            if (load) begin
                tag  <= load_addr;
                dout <= load_data;
            end
            if (inval)     valid <= 1'b0;
            else if (load) valid <= 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_sdram_mux.sv
// CH-client multiplexer onto one SDRAM bank port with per-channel hit caches.
// Handshake: ba_rd/ba_wr stay high until ba_ack is sampled; ba_rdy marks data/write completion.
module jtframe_sdram_mux
    import jtframe_sdram_mux_pkg::*;
#(
    parameter int CH = 4,
    parameter int AW = 22,
    parameter int DW = 16,
    parameter int RR = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             dwnld,
    input  logic [CH*AW-1:0] ch_addr,
    input  logic [CH-1:0]    ch_cs,
    input  logic             ch0_wr,
    input  logic [15:0]      ch0_din,
    input  logic [1:0]       ch0_din_m,
    output logic [CH*DW-1:0] ch_dout,
    output logic [CH-1:0]    ch_ok,
    output logic [AW-1:0]    ba_addr,
    output logic             ba_rd,
    output logic             ba_wr,
    output logic [15:0]      ba_din,
    output logic [1:0]       ba_din_m,
    input  logic             ba_ack,
    input  logic             ba_rdy,
    input  logic [31:0]      sdram_dout,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    logic [1:0]        st;
    logic [2:0]        gnt, ptr;
    logic              wr_op, wr_ok, inval;
    logic [DW-1:0]     rd_data;
    logic [CH-1:0]     hit, ok, cand;
    logic [MAX_CH-1:0] cand_ext;
    pick_t             pick;
    logic              unused_dout;

    assign unused_dout = &{1'b0, sdram_dout};

    always_comb begin
        cand     = ch_cs & ~hit;
        cand_ext = '0;
        cand_ext[CH-1:0] = cand;
        pick     = rr_pick(cand_ext, (RR != 0) ? ptr : 3'd0, CH);
    end

    assign inval     = dwnld | (st == ST_DONE && wr_op);
    assign busy      = (st != ST_IDLE);
    assign state_dbg = st;
    assign ch_ok     = ok | {{(CH-1){1'b0}}, wr_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            gnt      <= '0;
            ptr      <= '0;
            wr_op    <= 1'b0;
            wr_ok    <= 1'b0;
            rd_data  <= '0;
            ba_addr  <= '0;
            ba_rd    <= 1'b0;
            ba_wr    <= 1'b0;
            ba_din   <= '0;
            ba_din_m <= '0;
        end else begin
            wr_ok <= 1'b0;
            case (st)
                ST_IDLE: if (!dwnld && pick.found) begin
                    gnt      <= pick.idx;
                    ptr      <= (pick.idx == 3'(CH-1)) ? 3'd0 : pick.idx + 3'd1;
                    ba_addr  <= ch_addr[pick.idx*AW +: AW];
                    wr_op    <= (pick.idx == 3'd0) && ch0_wr;
                    ba_wr    <= (pick.idx == 3'd0) && ch0_wr;
                    ba_rd    <= !((pick.idx == 3'd0) && ch0_wr);
                    ba_din   <= ch0_din;
                    ba_din_m <= ch0_din_m;
                    st       <= ST_REQ;
                end
                ST_REQ: if (ba_ack) begin
                    ba_rd <= 1'b0;
                    ba_wr <= 1'b0;
                    if (ba_rdy) begin
                        rd_data <= sdram_dout[DW-1:0];
                        st      <= ST_DONE;
                    end else begin
                        st <= ST_WAIT;
                    end
                end
                ST_WAIT: if (ba_rdy) begin
                    rd_data <= sdram_dout[DW-1:0];
                    st      <= ST_DONE;
                end
                default: begin
                    wr_ok <= wr_op;
                    st    <= ST_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        jtframe_sdram_mux_cache #(.AW(AW), .DW(DW)) u_cache (
            .clk       (clk),
            .rst       (rst),
            .cs        (ch_cs[i]),
            .wr        ((i == 0) ? ch0_wr : 1'b0),
            .addr      (ch_addr[i*AW +: AW]),
            .load      (st == ST_DONE && !wr_op && gnt == 3'(i)),
            .load_addr (ba_addr),
            .load_data (rd_data),
            .inval     (inval),
            .hit       (hit[i]),
            .ok        (ok[i]),
            .dout      (ch_dout[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_jtframe_sdram_mux.sv
// Directed bench: a round-robin instance (a) and a fixed-priority instance (b) share the client bus.
module tb_jtframe_sdram_mux;
    localparam int CH = 4;
    localparam int AW = 22;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dwnld = 1'b0;
    logic [CH*AW-1:0] ch_addr = '0;
    logic [CH-1:0]    cs_a = '0, cs_b = '0;
    logic             ch0_wr = 1'b0;
    logic [15:0]      ch0_din = '0;
    logic [1:0]       ch0_din_m = '0;
    logic [31:0]      sdram_dout = '0;
    logic             ack_a = 1'b0, rdy_a = 1'b0, ack_b = 1'b0, rdy_b = 1'b0;

    logic [CH*DW-1:0] dout_a, dout_b;
    logic [CH-1:0]    ok_a, ok_b;
    logic [AW-1:0]    addr_a, addr_b;
    logic             rd_a, wr_a, rd_b, wr_b, busy_a, busy_b;
    logic [15:0]      din_a, din_b;
    logic [1:0]       m_a, m_b, st_a, st_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jtframe_sdram_mux #(.CH(CH), .AW(AW), .DW(DW), .RR(1)) dut_a (
        .clk(clk), .rst(rst), .dwnld(dwnld), .ch_addr(ch_addr), .ch_cs(cs_a),
        .ch0_wr(ch0_wr), .ch0_din(ch0_din), .ch0_din_m(ch0_din_m),
        .ch_dout(dout_a), .ch_ok(ok_a), .ba_addr(addr_a), .ba_rd(rd_a), .ba_wr(wr_a),
        .ba_din(din_a), .ba_din_m(m_a), .ba_ack(ack_a), .ba_rdy(rdy_a),
        .sdram_dout(sdram_dout), .busy(busy_a), .state_dbg(st_a)
    );

    jtframe_sdram_mux #(.CH(CH), .AW(AW), .DW(DW), .RR(0)) dut_b (
        .clk(clk), .rst(rst), .dwnld(dwnld), .ch_addr(ch_addr), .ch_cs(cs_b),
        .ch0_wr(ch0_wr), .ch0_din(ch0_din), .ch0_din_m(ch0_din_m),
        .ch_dout(dout_b), .ch_ok(ok_b), .ba_addr(addr_b), .ba_rd(rd_b), .ba_wr(wr_b),
        .ba_din(din_b), .ba_din_m(m_b), .ba_ack(ack_b), .ba_rdy(rdy_b),
        .sdram_dout(sdram_dout), .busy(busy_b), .state_dbg(st_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        ch_addr[i*AW +: AW] = a;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input bit b);
        int n = 0;
        while (!(b ? (rd_b | wr_b) : (rd_a | wr_a)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wait_req", b ? (rd_b | wr_b) : (rd_a | wr_a), 1);
    endtask

    // Called in the first REQ cycle; returns in the DONE cycle.
    task automatic serve(input bit b, input logic [31:0] data, input int ack_wait, input int rdy_gap);
        repeat (ack_wait) @(negedge clk);
        sdram_dout = data;
        if (b) ack_b = 1'b1; else ack_a = 1'b1;
        if (rdy_gap == 0) begin
            if (b) rdy_b = 1'b1; else rdy_a = 1'b1;
        end
        @(negedge clk);
        ack_a = 1'b0; ack_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
        if (rdy_gap > 0) begin
            repeat (rdy_gap - 1) @(negedge clk);
            if (b) rdy_b = 1'b1; else rdy_a = 1'b1;
            @(negedge clk);
            rdy_a = 1'b0; rdy_b = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        @(negedge clk);
        check("rst_rd", rd_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ok", ok_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_dout_lo", dout_a[31:0], 0);
        check("rst_dout_hi", dout_a[63:32], 0);
        check("rst_state", st_a, 0);
        check("rst_busy_b", busy_b, 0);
        rst = 1'b0;

        // round-robin with all four channels missing
        for (int i = 0; i < CH; i++) set_addr(i, 22'h100 + 22'(i));
        cs_a = 4'hF;
        for (int k = 0; k < CH; k++) begin
            wait_req(0);
            check("rr_addr", addr_a, 32'h100 + k);
            check("rr_ok", ok_a, (1 << k) - 1);
            serve(0, 32'hDEAD_1000 + k, 0, 2);
        end
        step(2);
        check("rr_ok_all", ok_a, 4'hF);
        check("rr_idle_rd", rd_a, 0);
        check("rr_idle_busy", busy_a, 0);
        for (int k = 0; k < CH; k++) check("rr_dout", dout_a[k*DW +: DW], 32'h1000 + k);

        set_addr(0, 22'h200);
        wait_req(0);
        check("rr_wrap_addr", addr_a, 22'h200);
        check("rr_wrap_ok", ok_a, 4'b1110);
        serve(0, 32'h0000_2000, 0, 2);
        step(2);
        check("rr_wrap_ok_back", ok_a, 4'hF);
        set_addr(0, 22'h300);
        set_addr(3, 22'h303);
        wait_req(0);
        check("rr_ptr_addr3", addr_a, 22'h303);
        serve(0, 32'h0000_3030, 0, 2);
        wait_req(0);
        check("rr_ptr_addr0", addr_a, 22'h300);
        serve(0, 32'h0000_3000, 0, 2);
        step(2);

        // hit path
        set_addr(2, 22'h1234);
        wait_req(0);
        check("hit_miss_addr", addr_a, 22'h1234);
        serve(0, 32'hBEEF_CAFE, 0, 2);
        step(2);
        check("hit_dout", dout_a[2*DW +: DW], 16'hCAFE);
        check("hit_ok_first", ok_a[2], 1);
        cs_a[2] = 1'b0;
        @(negedge clk);
        check("hit_ok_drop", ok_a[2], 0);
        cs_a[2] = 1'b1;
        @(negedge clk);
        check("hit_ok_again", ok_a[2], 1);
        check("hit_no_rd", rd_a, 0);
        check("hit_not_busy", busy_a, 0);

        // channel 0 write invalidates every cache entry
        set_addr(0, 22'h040);
        ch0_wr = 1'b1;
        ch0_din = 16'h55AA;
        ch0_din_m = 2'b10;
        @(negedge clk);
        check("wr_ba_wr", wr_a, 1);
        check("wr_ba_rd", rd_a, 0);
        check("wr_din", din_a, 16'h55AA);
        check("wr_mask", m_a, 2'b10);
        check("wr_addr", addr_a, 22'h040);
        check("wr_ok0_low", ok_a[0], 0);
        serve(0, 32'h0, 0, 1);
        cs_a[0] = 1'b0;
        ch0_wr = 1'b0;
        @(negedge clk);
        check("wr_ok_pulse", ok_a, 4'hF);
        wait_req(0);
        check("wr_after_ok", ok_a, 0);
        check("wr_refetch_addr1", addr_a, 22'h101);
        serve(0, 32'h0000_0101, 0, 1);
        wait_req(0);
        check("wr_refetch_addr2", addr_a, 22'h1234);
        serve(0, 32'h0000_1234, 0, 1);
        wait_req(0);
        check("wr_refetch_addr3", addr_a, 22'h303);
        serve(0, 32'h0000_0303, 0, 1);
        step(2);
        check("wr_refill_ok", ok_a, 4'b1110);
        cs_a = '0;

        // fixed priority on instance b
        cs_b = 4'b1010;
        wait_req(1);
        check("fp_first", addr_b, 22'h101);
        serve(1, 32'h0000_0B01, 0, 1);
        wait_req(1);
        check("fp_second", addr_b, 22'h303);
        serve(1, 32'h0000_0B03, 0, 1);
        step(2);
        check("fp_ok", ok_b, 4'b1010);
        check("fp_idle", busy_b, 0);
        set_addr(1, 22'h111);
        wait_req(1);
        check("fp_ch1_again", addr_b, 22'h111);
        serve(1, 32'h0000_0111, 0, 1);
        step(2);
        set_addr(1, 22'h121);
        set_addr(3, 22'h323);
        wait_req(1);
        check("fp_low_wins", addr_b, 22'h121);
        serve(1, 32'h0000_0121, 0, 1);
        wait_req(1);
        check("fp_then_ch3", addr_b, 22'h323);
        serve(1, 32'h0000_0323, 0, 1);
        cs_b = '0;
        step(2);

        // download hold-off during WAIT
        set_addr(1, 22'h777);
        cs_a = 4'b0010;
        wait_req(0);
        check("dl_addr", addr_a, 22'h777);
        ack_a = 1'b1;
        sdram_dout = 32'h0000_7777;
        @(negedge clk);
        ack_a = 1'b0;
        check("dl_wait_state", st_a, 2'd2);
        dwnld = 1'b1;
        @(negedge clk);
        rdy_a = 1'b1;
        check("dl_busy", busy_a, 1);
        @(negedge clk);
        rdy_a = 1'b0;
        @(negedge clk);
        check("dl_idle", busy_a, 0);
        cs_a = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("dl_no_rd", rd_a, 0);
            check("dl_ok_low", ok_a, 0);
        end
        dwnld = 1'b0;
        @(negedge clk);
        check("dl_resume_rd", rd_a, 1);
        check("dl_resume_addr", addr_a, 22'h1234);
        serve(0, 32'h0000_1234, 0, 1);
        wait_req(0);
        check("dl_refetch", addr_a, 22'h777);
        serve(0, 32'h0000_0777, 0, 1);
        cs_a = '0;
        step(2);

        // ack and rdy in the same cycle, then reset mid-REQ
        set_addr(3, 22'h3AB);
        cs_a = 4'b1000;
        wait_req(0);
        check("sc_addr", addr_a, 22'h3AB);
        serve(0, 32'h1111_3AB0, 0, 0);
        check("sc_done_state", st_a, 2'd3);
        check("sc_rd_low", rd_a, 0);
        step(2);
        check("sc_ok", ok_a, 4'b1000);
        check("sc_dout", dout_a[3*DW +: DW], 16'h3AB0);
        set_addr(3, 22'h3AC);
        wait_req(0);
        #2 rst = 1'b1;
        #1;
        check("arst_rd", rd_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_ok", ok_a, 0);
        check("arst_state", st_a, 0);
        @(negedge clk);
        rst = 1'b0;
        cs_a = 4'b0100;
        @(negedge clk);
        check("arst_cache_miss", rd_a, 1);
        check("arst_miss_addr", addr_a, 22'h1234);
        check("arst_miss_ok", ok_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
